// File: rtl/motion_pkg.sv
// Shared types and widths for the sprite motion controller.
package motion_pkg;

  typedef enum logic [1:0] {
    MS_RUN     = 2'd0,
    MS_HIT     = 2'd1,
    MS_RESPAWN = 2'd2
  } motion_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned SPRITE_W = 64;
  localparam int unsigned SPRITE_H = 64;
  localparam int unsigned POS_W    = 11;
  localparam int unsigned VEL_W    = 5;
  // Signed width wide enough for position plus velocity without wrap.
  localparam int unsigned CALC_W   = 13;

endpackage

// File: rtl/axis_motion.sv
// One motion axis: velocity ramp/decay, position integrate, edge clamp.
module axis_motion
  import motion_pkg::*;
#(
  parameter int MIN       = 0,
  parameter int MAX       = 576,
  parameter int INIT      = 288,
  parameter int ACCEL     = 1,
  parameter int DECEL     = 1,
  parameter int MAX_SPEED = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    tick,
  input  logic                    neg,
  input  logic                    pos,
  input  logic                    freeze,
  input  logic                    load_init,
  output logic [POS_W-1:0]        pos_out,
  output logic signed [VEL_W-1:0] vel_out
);

  localparam logic signed [CALC_W-1:0] L_ACCEL  = CALC_W'(ACCEL);
  localparam logic signed [CALC_W-1:0] L_DECEL  = CALC_W'(DECEL);
  localparam logic signed [CALC_W-1:0] L_NDECEL = CALC_W'(-DECEL);
  localparam logic signed [CALC_W-1:0] L_VMAX   = CALC_W'(MAX_SPEED);
  localparam logic signed [CALC_W-1:0] L_VMIN   = CALC_W'(-MAX_SPEED);
  localparam logic signed [CALC_W-1:0] L_MIN    = CALC_W'(MIN);
  localparam logic signed [CALC_W-1:0] L_MAX    = CALC_W'(MAX);

  logic [POS_W-1:0]         r_pos;
  logic signed [VEL_W-1:0]  r_vel;
  logic signed [CALC_W-1:0] w_v_cur;
  logic signed [CALC_W-1:0] w_v_new;
  logic signed [CALC_W-1:0] w_v_fin;
  logic signed [CALC_W-1:0] w_p_cur;
  logic signed [CALC_W-1:0] w_p_sum;
  logic signed [CALC_W-1:0] w_p_new;

  // Next velocity from net direction, then next position with edge clamp.
  always_comb begin
    w_v_cur = {{(CALC_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};
    w_p_cur = {{(CALC_W-POS_W){1'b0}}, r_pos};
    w_v_new = w_v_cur;
    if (pos && !neg) begin
      w_v_new = w_v_cur + L_ACCEL;
      if (w_v_new > L_VMAX) w_v_new = L_VMAX;
    end else if (neg && !pos) begin
      w_v_new = w_v_cur - L_ACCEL;
      if (w_v_new < L_VMIN) w_v_new = L_VMIN;
    end else if (w_v_cur > L_DECEL) begin
      w_v_new = w_v_cur - L_DECEL;
    end else if (w_v_cur < L_NDECEL) begin
      w_v_new = w_v_cur + L_DECEL;
    end else begin
      w_v_new = '0;
    end
    w_p_sum = w_p_cur + w_v_new;
    w_p_new = w_p_sum;
    w_v_fin = w_v_new;
    if (w_p_sum < L_MIN) begin
      w_p_new = L_MIN;
      w_v_fin = '0;
    end else if (w_p_sum > L_MAX) begin
      w_p_new = L_MAX;
      w_v_fin = '0;
    end
  end

  // Axis state advances only on a frame tick; init load wins over freeze.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_pos <= POS_W'(INIT);
      r_vel <= '0;
    end else if (tick) begin
      if (load_init) begin
        r_pos <= POS_W'(INIT);
        r_vel <= '0;
      end else if (freeze) begin
        r_vel <= '0;
      end else begin
        r_pos <= POS_W'(w_p_new);
        r_vel <= VEL_W'(w_v_fin);
      end
    end
  end

  assign pos_out = r_pos;
  assign vel_out = r_vel;

endmodule

// File: rtl/object_motion_control.sv
// Per-frame 2D sprite controller: two motion axes plus hit/respawn sequencing.
module object_motion_control
  import motion_pkg::*;
#(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = int'(SCREEN_W - SPRITE_W),
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = int'(SCREEN_H - SPRITE_H),
  parameter int INIT_X         = 288,
  parameter int INIT_Y         = 352,
  parameter int ACCEL          = 1,
  parameter int DECEL          = 1,
  parameter int MAX_SPEED      = 8,
  parameter int HIT_FRAMES     = 60,
  parameter int RESPAWN_FRAMES = 120,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              up_pressed,
  input  logic              down_pressed,
  input  logic              left_pressed,
  input  logic              right_pressed,
  input  logic              collision,
  output logic [10:0]       topLeftX,
  output logic [10:0]       topLeftY,
  output logic signed [4:0] vel_x,
  output logic signed [4:0] vel_y,
  output logic [1:0]        motion_state,
  output logic              visible
);

  localparam int unsigned CNT_MAX = unsigned'((HIT_FRAMES > RESPAWN_FRAMES) ? HIT_FRAMES : RESPAWN_FRAMES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BLK_W   = $clog2(unsigned'(BLINK_FRAMES) + 1);

  motion_state_t    r_state;
  logic             r_sof_d;
  logic             r_col_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_visible;

  logic w_frame_tick;
  logic w_hit_now;
  logic w_freeze;
  logic w_load_init;

  // Rising-edge frame strobe and per-axis control qualifiers.
  always_comb begin
    w_frame_tick = startOfFrame & ~r_sof_d;
    w_hit_now    = (r_state == MS_RUN) & (r_col_pend | collision);
    w_freeze     = (r_state != MS_RUN) | w_hit_now;
    w_load_init  = ((r_state == MS_HIT) & (r_cnt == '0)) | (r_state == MS_RESPAWN);
  end

  // Run/hit/respawn sequencing, frame counters, blink and sticky collision.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_sof_d     <= 1'b0;
      r_col_pend  <= 1'b0;
      r_state     <= MS_RUN;
      r_cnt       <= '0;
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else begin
      r_sof_d <= startOfFrame;
      if (w_frame_tick) begin
        r_col_pend <= 1'b0;
        case (r_state)
          MS_RUN: begin
            if (w_hit_now) begin
              r_state <= MS_HIT;
              r_cnt   <= CNT_W'(HIT_FRAMES - 1);
            end
          end
          MS_HIT: begin
            r_visible <= 1'b1;
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_state     <= MS_RESPAWN;
              r_cnt       <= CNT_W'(RESPAWN_FRAMES - 1);
              r_blink_cnt <= BLK_W'(BLINK_FRAMES - 1);
              r_visible   <= 1'b0;
            end
          end
          MS_RESPAWN: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
              if (r_blink_cnt == '0) begin
                r_visible   <= ~r_visible;
                r_blink_cnt <= BLK_W'(BLINK_FRAMES - 1);
              end else begin
                r_blink_cnt <= r_blink_cnt - BLK_W'(1);
              end
            end else begin
              r_state   <= MS_RUN;
              r_visible <= 1'b1;
            end
          end
          default: begin
            r_state   <= MS_RUN;
            r_visible <= 1'b1;
          end
        endcase
      end else if (collision) begin
        r_col_pend <= 1'b1;
      end
    end
  end

  axis_motion #(
    .MIN(X_MIN), .MAX(X_MAX), .INIT(INIT_X),
    .ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)
  ) u_axis_x (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (w_frame_tick),
    .neg       (left_pressed),
    .pos       (right_pressed),
    .freeze    (w_freeze),
    .load_init (w_load_init),
    .pos_out   (topLeftX),
    .vel_out   (vel_x)
  );

  axis_motion #(
    .MIN(Y_MIN), .MAX(Y_MAX), .INIT(INIT_Y),
    .ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)
  ) u_axis_y (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (w_frame_tick),
    .neg       (up_pressed),
    .pos       (down_pressed),
    .freeze    (w_freeze),
    .load_init (w_load_init),
    .pos_out   (topLeftY),
    .vel_out   (vel_y)
  );

  assign motion_state = r_state;
  assign visible      = r_visible;

endmodule

// File: tb/tb_object_motion_control.sv
// Directed plus randomized frames against a frame-level behavioural model.
module tb_object_motion_control;

  localparam int X_MIN = 0, X_MAX = 576, Y_MIN = 0, Y_MAX = 416;
  localparam int INIT_X = 288, INIT_Y = 352;
  localparam int ACCEL = 1, DECEL = 1, MAX_SPEED = 8;
  localparam int HIT_FRAMES = 60, RESPAWN_FRAMES = 120, BLINK_FRAMES = 8;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              up_pressed = 1'b0, down_pressed = 1'b0;
  logic              left_pressed = 1'b0, right_pressed = 1'b0;
  logic              collision = 1'b0;
  logic [10:0]       topLeftX, topLeftY;
  logic signed [4:0] vel_x, vel_y;
  logic [1:0]        motion_state;
  logic              visible;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 run, 1 frozen after hit, 2 respawning; k = ticks since entering mode.
  int mx, my, mvx, mvy, mmode, mk;

  object_motion_control dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .up_pressed(up_pressed), .down_pressed(down_pressed),
    .left_pressed(left_pressed), .right_pressed(right_pressed),
    .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .vel_x(vel_x), .vel_y(vel_y),
    .motion_state(motion_state), .visible(visible)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_vis();
    if (mmode == 2) return ((mk / BLINK_FRAMES) % 2 == 1) ? 1 : 0;
    return 1;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".x"},   int'(topLeftX), mx);
    chk({tag, ".y"},   int'(topLeftY), my);
    chk({tag, ".vx"},  int'(vel_x), mvx);
    chk({tag, ".vy"},  int'(vel_y), mvy);
    chk({tag, ".st"},  int'(motion_state), mmode);
    chk({tag, ".vis"}, int'(visible), model_vis());
  endtask

  task automatic model_reset();
    mx = INIT_X; my = INIT_Y; mvx = 0; mvy = 0; mmode = 0; mk = 0;
  endtask

  task automatic axis_step(input int p, input int v, input int dir, input int lo, input int hi,
                           output int p_o, output int v_o);
    int nv, np;
    if (dir != 0) begin
      nv = v + dir * ACCEL;
      if (nv > MAX_SPEED) nv = MAX_SPEED;
      if (nv < -MAX_SPEED) nv = -MAX_SPEED;
    end else if (v > 0) begin
      nv = (v > DECEL) ? v - DECEL : 0;
    end else begin
      nv = (v < -DECEL) ? v + DECEL : 0;
    end
    np = p + nv;
    if (np < lo) begin np = lo; nv = 0; end
    else if (np > hi) begin np = hi; nv = 0; end
    p_o = np; v_o = nv;
  endtask

  task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input bit hit);
    int dx, dy;
    dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
    case (mmode)
      0: begin
        if (hit) begin
          mmode = 1; mk = 0; mvx = 0; mvy = 0;
        end else begin
          axis_step(mx, mvx, dx, X_MIN, X_MAX, mx, mvx);
          axis_step(my, mvy, dy, Y_MIN, Y_MAX, my, mvy);
        end
      end
      1: begin
        mk++;
        if (mk == HIT_FRAMES) begin
          mmode = 2; mk = 0; mx = INIT_X; my = INIT_Y; mvx = 0; mvy = 0;
        end
      end
      default: begin
        mk++;
        if (mk == RESPAWN_FRAMES) begin mmode = 0; mk = 0; end
      end
    endcase
  endtask

  // col_mode: 0 none, 1 one-cycle pulse mid-frame, 2 coincident with the frame edge.
  task automatic frame(input bit u, input bit d, input bit l, input bit r,
                       input int col_mode, input int sof_len);
    up_pressed = u; down_pressed = d; left_pressed = l; right_pressed = r;
    if (col_mode == 1) begin
      collision = 1'b1; step(); collision = 1'b0; step();
    end
    startOfFrame = 1'b1;
    if (col_mode == 2) collision = 1'b1;
    step();
    collision = 1'b0;
    repeat (sof_len - 1) step();
    startOfFrame = 1'b0;
    step();
    model_tick(u, d, l, r, col_mode != 0);
  endtask

  task automatic rand_frame(input string tag, input int col_pct);
    int cm;
    cm = 0;
    if (int'($urandom_range(99)) < col_pct) cm = int'($urandom_range(2, 1));
    frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), cm,
          int'($urandom_range(4, 1)));
    chk_all(tag);
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
    up_pressed = 1'b0; down_pressed = 1'b0; left_pressed = 1'b0; right_pressed = 1'b0;
    step(); step();
    resetN = 1'b1;
    step();
    model_reset();
  endtask

  initial begin
    int exp_vy[6];
    int exp_y[6];
    exp_vy = '{-1, -2, -3, -2, -1, 0};
    exp_y  = '{351, 349, 346, 344, 343, 343};

    // Reset values
    do_reset();
    chk("rst.x", int'(topLeftX), 288);
    chk("rst.y", int'(topLeftY), 352);
    chk("rst.vx", int'(vel_x), 0);
    chk("rst.vy", int'(vel_y), 0);
    chk("rst.st", int'(motion_state), 0);
    chk("rst.vis", int'(visible), 1);

    // Up held three frames, then released three frames
    for (int i = 0; i < 6; i++) begin
      frame(i < 3, 1'b0, 1'b0, 1'b0, 0, 1);
      chk("ramp.vy", int'(vel_y), exp_vy[i]);
      chk("ramp.y", int'(topLeftY), exp_y[i]);
      chk_all("ramp");
    end

    // Opposing keys cancel
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 1'b1, 1'b0, 1'b0, 0, 1);
      chk_all("cancel");
    end
    chk("cancel.y", int'(topLeftY), 343);

    // Right held ten frames saturates at MAX_SPEED
    for (int i = 0; i < 10; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
      chk_all("sat");
    end
    chk("sat.vx", int'(vel_x), 8);
    chk("sat.x", int'(topLeftX), 340);

    // Right edge clamp zeroes velocity
    for (int i = 0; i < 40; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
      chk_all("xmax");
    end
    chk("xmax.x", int'(topLeftX), X_MAX);
    chk("xmax.vx", int'(vel_x), 0);

    // Top edge clamp
    for (int i = 0; i < 60; i++) begin
      frame(1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
      chk_all("ymin");
    end
    chk("ymin.y", int'(topLeftY), Y_MIN);
    chk("ymin.vy", int'(vel_y), 0);

    // Level strobe held five cycles gives one update
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 1'b1, 0, 5);
    chk("level.vx", int'(vel_x), 1);
    chk("level.x", int'(topLeftX), 289);
    chk_all("level");

    // Mid-frame collision: hit, freeze, respawn with blink, back to run
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
      chk_all("prehit");
    end
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
    chk("hit.st", int'(motion_state), 1);
    chk("hit.vx", int'(vel_x), 0);
    chk_all("hit");
    for (int i = 0; i < HIT_FRAMES + RESPAWN_FRAMES; i++) rand_frame("seq", 30);
    chk("back.st", int'(motion_state), 0);
    chk("back.vis", int'(visible), 1);
    chk("back.x", int'(topLeftX), INIT_X);
    chk("back.y", int'(topLeftY), INIT_Y);

    // Random motion with occasional collisions
    for (int i = 0; i < 300; i++) rand_frame("rnd", (mmode == 0) ? 2 : 10);

    // Reset during HIT coincident with a frame edge
    do_reset();
    frame(1'b0, 1'b0, 1'b1, 1'b0, 2, 1);
    chk("hit2.st", int'(motion_state), 1);
    for (int i = 0; i < 3; i++) rand_frame("hit2", 0);
    resetN = 1'b0; startOfFrame = 1'b1;
    step();
    resetN = 1'b1; startOfFrame = 1'b0;
    model_reset();
    chk_all("rst_hit");
    step();
    chk_all("rst_hit2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
